// File: rtl/instr_seq_pkg.sv
// instr_seq_pkg: shared FSM state type and default parameters for the instruction sequencer.
package instr_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_HALT_WORD = 0;

endpackage

// File: rtl/instr_seq_ram.sv
// instr_seq_ram: program storage with one synchronous write port and one synchronous read port.
module instr_seq_ram #(
    parameter int W  = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_seq_mem.sv
// instr_seq_mem: instruction memory with a sequencing FSM (IDLE/RUN/DONE) and valid/ready fetch port.
// Optional INSTR_SEQ_MEM_PARITY_EN adds a stored even-parity bit per word and a sticky parity_err output.
module instr_seq_mem
    import instr_seq_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(DEF_HALT_WORD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
`ifdef INSTR_SEQ_MEM_PARITY_EN
    ,output logic             parity_err
`endif
);

`ifdef INSTR_SEQ_MEM_PARITY_EN
    localparam int RW = DATA_W + 1;
`else
    localparam int RW = DATA_W;
`endif

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic [DATA_W-1:0] instr_d;
    logic              valid_d, go, jmp, fetch, halt;
    logic [RW-1:0]     wdata, rdata;

`ifdef INSTR_SEQ_MEM_PARITY_EN
    logic perr_d;
    assign wdata = {^load_data, load_data};
`else
    assign wdata = load_data;
`endif

    // Read address follows pc_d so rdata already holds mem[pc] when a fetch is decided.
    instr_seq_ram #(.W(RW), .AW(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (load_en && state != RUN),
        .waddr (load_addr),
        .wdata (wdata),
        .raddr (pc_d),
        .rdata (rdata)
    );

    always_comb begin
        go      = start && !load_en && state != RUN;
        jmp     = state == RUN && jump_en;
        fetch   = state == RUN && !jump_en && (!instr_valid || instr_ready);
        halt    = fetch && rdata[DATA_W-1:0] == HALT_WORD;
        pc_d    = go ? start_addr : jmp ? jump_addr : fetch ? pc + 1'b1 : pc;
        instr_d = fetch ? rdata[DATA_W-1:0] : instr;
        valid_d = (go || jmp) ? 1'b0 : fetch ? !halt : instr_valid && !instr_ready;
        state_d = go ? RUN : halt ? DONE : state;
`ifdef INSTR_SEQ_MEM_PARITY_EN
        perr_d  = go ? 1'b0 : parity_err || (fetch && !halt && ^rdata);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
`ifdef INSTR_SEQ_MEM_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            instr       <= instr_d;
            instr_valid <= valid_d;
`ifdef INSTR_SEQ_MEM_PARITY_EN
            parity_err  <= perr_d;
`endif
        end
    end

    assign busy = state == RUN;
    assign done = state == DONE;

endmodule

// File: tb/tb_instr_seq_mem.sv
// tb_instr_seq_mem: table-driven programs plus hand-written corner sequences, scoreboarded on accepted beats.
module tb_instr_seq_mem;

    logic        clk = 0, rst_n = 0, load_en = 0, start = 0, jump_en = 0, instr_ready = 0;
    logic [7:0]  load_addr = 0, start_addr = 0, jump_addr = 0;
    logic [31:0] load_data = 0;
    logic [31:0] instr;
    logic        instr_valid, busy, done;
    logic [7:0]  pc;
`ifdef INSTR_SEQ_MEM_PARITY_EN
    logic        parity_err;
`endif

    int n_cmp = 0, n_err = 0;
    logic [31:0] q[$];

    typedef struct {
        logic [7:0]       base;
        logic [3:0][31:0] w;
        bit               rnd;
        logic [7:0]       pc_end;
    } vec_t;
    vec_t tv[5];

    instr_seq_mem dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .start(start), .start_addr(start_addr), .jump_en(jump_en), .jump_addr(jump_addr),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
        .busy(busy), .done(done)
`ifdef INSTR_SEQ_MEM_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Every beat accepted by the consumer is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got %0h expected none", instr);
            end else chk("sb_instr", instr, q.pop_front());
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [7:0] a, input logic [31:0] d);
        load_en = 1; load_addr = a; load_data = d;
        sync();
        load_en = 0;
    endtask

    task automatic go(input logic [7:0] a);
        start = 1; start_addr = a;
        sync();
        start = 0;
    endtask

    task automatic wait_valid();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (instr_valid) break;
            sync();
        end
        chk("valid_timeout", instr_valid, 1);
    endtask

    task automatic run_until_done(input bit rnd);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) break;
            sync();
            if (rnd) instr_ready = 1'($urandom_range(0, 1));
        end
        chk("done_timeout", done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{8'd0,   {32'd0, 32'd3, 32'd2, 32'd1},                     1'b0, 8'd4};
        tv[1] = '{8'd255, {32'd0, 32'd0, 32'd0, 32'd7},                     1'b0, 8'd1};
        tv[2] = '{8'd100, {32'd5, 32'd0, 32'h12345678, 32'hdeadbeef},       1'b1, 8'd103};
        tv[3] = '{8'd20,  {32'd9, 32'd9, 32'd9, 32'd0},                     1'b0, 8'd21};
        tv[4] = '{8'd200, {32'd0, 32'h0c, 32'h0b, 32'h0a},                  1'b1, 8'd204};

        #12;
        chk("rst_pc", pc, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1 rst_n = 1;
        sync();

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) ld(8'(tv[i].base + j), tv[i].w[j]);
            for (int j = 0; j < 4; j++) begin
                if (tv[i].w[j] == 0) break;
                q.push_back(tv[i].w[j]);
            end
            instr_ready = 1;
            go(tv[i].base);
            run_until_done(tv[i].rnd);
            chk("tv_pc_end", pc, tv[i].pc_end);
            chk("tv_busy", busy, 0);
            chk("tv_valid", instr_valid, 0);
            chk("tv_sb_empty", q.size(), 0);
            sync();
        end
        instr_ready = 1;

        // jump outside RUN must not move pc
        jump_en = 1; jump_addr = 10;
        sync();
        jump_en = 0;
        @(negedge clk);
        chk("done_jump_pc", pc, 204);
        chk("done_jump_done", done, 1);
        sync();

        // load and start together: write happens, start ignored
        ld(51, 0);
        load_en = 1; load_addr = 50; load_data = 32'h55; start = 1; start_addr = 50;
        sync();
        load_en = 0; start = 0;
        @(negedge clk);
        chk("ldst_busy", busy, 0);
        chk("ldst_done", done, 1);
        sync();
        q.push_back(32'h55);
        go(50);
        run_until_done(0);
        chk("ldst_pc", pc, 52);
        sync();

        // back-pressure holds instr and pc
        ld(0, 1); ld(1, 2); ld(2, 3); ld(3, 0);
        instr_ready = 0;
        q.push_back(1); q.push_back(2); q.push_back(3);
        go(0);
        wait_valid();
        chk("bp_instr", instr, 1);
        chk("bp_pc", pc, 1);
        for (int k = 0; k < 3; k++) begin
            sync();
            @(negedge clk);
            chk("bp_hold_instr", instr, 1);
            chk("bp_hold_pc", pc, 1);
            chk("bp_hold_valid", instr_valid, 1);
        end
        sync();
        instr_ready = 1;
        run_until_done(0);
        chk("bp_pc_end", pc, 4);
        chk("bp_sb_empty", q.size(), 0);
        sync();

        // pc wrap from 255 to 0
        ld(255, 7); ld(0, 0);
        instr_ready = 0;
        q.push_back(7);
        go(255);
        wait_valid();
        chk("wrap_instr", instr, 7);
        chk("wrap_pc", pc, 0);
        sync();
        instr_ready = 1;
        run_until_done(0);
        chk("wrap_pc_end", pc, 1);
        sync();

        // jump flushes pending instr 2
        ld(0, 1); ld(1, 2); ld(2, 3); ld(3, 0); ld(10, 9); ld(11, 0);
        instr_ready = 0;
        go(0);
        wait_valid();
        q.push_back(1);
        sync();
        instr_ready = 1;
        sync();
        instr_ready = 0;
        @(negedge clk);
        chk("jmp_pending", instr, 2);
        chk("jmp_pending_valid", instr_valid, 1);
        sync();
        jump_en = 1; jump_addr = 10;
        sync();
        jump_en = 0;
        @(negedge clk);
        chk("jmp_flush_valid", instr_valid, 0);
        chk("jmp_pc", pc, 10);
        sync();
        q.push_back(9);
        instr_ready = 1;
        run_until_done(0);
        chk("jmp_pc_end", pc, 12);
        chk("jmp_sb_empty", q.size(), 0);
        sync();

        // load during RUN is ignored
        ld(60, 32'h11); ld(61, 32'h22); ld(62, 0);
        instr_ready = 0;
        q.push_back(32'h11); q.push_back(32'h22);
        go(60);
        wait_valid();
        chk("run_ld_instr", instr, 32'h11);
        sync();
        ld(61, 32'h99);
        sync();
        sync();
        instr_ready = 1;
        run_until_done(0);
        chk("run_ld_pc_end", pc, 63);
        sync();

        // reset mid-run aborts but keeps memory
        instr_ready = 0;
        go(60);
        wait_valid();
        sync();
        rst_n = 0;
        #1;
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_instr", instr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        sync();
        rst_n = 1;
        sync();
        q.push_back(32'h11); q.push_back(32'h22);
        instr_ready = 1;
        go(60);
        run_until_done(0);
        chk("mid_rst_pc_end", pc, 63);
        chk("mid_rst_sb_empty", q.size(), 0);
        sync();

`ifdef INSTR_SEQ_MEM_PARITY_EN
        ld(0, 1); ld(1, 2); ld(2, 3); ld(3, 0);
        dut.u_ram.mem[1][0] = ~dut.u_ram.mem[1][0];
        instr_ready = 0;
        q.push_back(1); q.push_back(3); q.push_back(3);
        go(0);
        wait_valid();
        chk("par_clean", parity_err, 0);
        sync();
        instr_ready = 1;
        sync();
        instr_ready = 0;
        @(negedge clk);
        chk("par_err", parity_err, 1);
        chk("par_err_valid", instr_valid, 1);
        sync();
        instr_ready = 1;
        run_until_done(0);
        sync();
        chk("par_sticky", parity_err, 1);
        go(0);
        chk("par_start_clear", parity_err, 0);
        q.push_back(1); q.push_back(3); q.push_back(3);
        run_until_done(0);
        sync();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_seq_mem.md
INSTR_SEQ_MEM -- requirements
Module: instr_seq_mem

Interface
REQ-001 Parameter DATA_W, default 32: instruction word width in bits.
REQ-002 Parameter ADDR_W, default 8: address width; depth = 2**ADDR_W words.
REQ-003 Parameter HALT_WORD, default 0: word value that terminates a program run (the Null instruction).
REQ-004 Port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port load_en, input, 1 bit: write strobe for the program-load port.
REQ-007 Port load_addr, input, ADDR_W bits: write address.
REQ-008 Port load_data, input, DATA_W bits: write data.
REQ-009 Port start, input, 1 bit: begin a run.
REQ-010 Port start_addr, input, ADDR_W bits: first program counter (PC) value of the run.
REQ-011 Port jump_en, input, 1 bit: redirect the PC.
REQ-012 Port jump_addr, input, ADDR_W bits: jump target.
REQ-013 Port instr, output, DATA_W bits: fetched instruction.
REQ-014 Port instr_valid, output, 1 bit: instr holds a valid instruction.
REQ-015 Port instr_ready, input, 1 bit: the consumer accepts instr.
REQ-016 Port pc, output, ADDR_W bits: address of the next word to fetch.
REQ-017 Port busy, output, 1 bit: the FSM is in RUN.
REQ-018 Port done, output, 1 bit: the FSM is in DONE.

Function
REQ-019 FSM states are IDLE, RUN and DONE; the reset state is IDLE.
REQ-020 IDLE->RUN on start; DONE->RUN on start; RUN->DONE when HALT_WORD is read; RUN->IDLE never occurs except on reset.
REQ-021 On start: pc<=start_addr, instr_valid<=0, done<=0.
REQ-022 A memory write (mem[load_addr]<=load_data) occurs only in IDLE or DONE; load_en is ignored in RUN.
REQ-023 load_en and start asserted in the same cycle: the write occurs, start is ignored.
REQ-024 Fetch condition, RUN only: (!instr_valid || instr_ready); on fetch, instr<=mem[pc], instr_valid<=1, pc<=pc+1.
REQ-025 Fetch latency is one cycle from the PC value to instr.
REQ-026 Back-to-back fetches give one instruction per cycle while instr_ready=1.
REQ-027 Back-pressure: while instr_valid && !instr_ready, instr, instr_valid and pc are held stable.
REQ-028 PC increment wraps from 2**ADDR_W-1 to 0.
REQ-029 If the fetched word equals HALT_WORD, it is not presented: instr_valid<=0 and state<=DONE.
REQ-030 Any previously valid, unaccepted instr is still presented in DONE until it is accepted.
REQ-031 jump_en in RUN: pc<=jump_addr and instr_valid<=0 (the pending instruction is flushed); no fetch occurs that cycle.
REQ-032 jump_en outside RUN is ignored.
REQ-033 jump_en wins over the fetch condition in the same cycle.
REQ-034 The memory has no initial contents; the program is loaded only through the load port.

Reset
REQ-035 While rst_n=0: state=IDLE, pc=0, instr=0, instr_valid=0, busy=0, done=0.
REQ-036 Reset mid-RUN aborts the run with no further fetch; memory contents are preserved.

Configuration
REQ-037 Macro INSTR_SEQ_MEM_PARITY_EN defined: each word stores an even-parity bit computed on write, and the block adds output parity_err (1 bit).
REQ-038 parity_err is asserted together with instr_valid when the fetched word fails its parity check.
REQ-039 parity_err is a sticky bit, cleared by reset or start.
REQ-040 Macro INSTR_SEQ_MEM_PARITY_EN undefined: no parity storage and no parity_err port.

Structure
REQ-041 The shared package instr_seq_pkg holds the FSM state typedef (IDLE, RUN, DONE) and the default parameter constants.
REQ-042 The storage array is a sub-module, instr_seq_ram: one synchronous write port and one synchronous read port.

Verification
REQ-043 Reset release: pc=0, instr_valid=0, busy=0, done=0.
REQ-044 Load mem[0..3]=1,2,3,0; start with start_addr=0 and instr_ready=1 -> instr 1,2,3 on consecutive cycles, then done=1 and pc=4.
REQ-045 Same program with instr_ready=0 for 3 cycles after the first valid -> instr=1 held stable and pc=1 held, then the sequence resumes unchanged.
REQ-046 Load mem[255]=7 and mem[0]=0; start with start_addr=255 -> instr=7, pc wraps to 0, then done=1.
REQ-047 jump_en with jump_addr=10 while instr=2 is pending -> instr_valid drops, and the next instr is mem[10].
REQ-048 Under PARITY_EN, force a bit flip in mem[1] -> parity_err=1 with instr_valid on that fetch; start clears parity_err.
